// File: rtl/collision_judge.sv
// collision_judge: per-frame AABB collision check of the dino against three
// danger slots, run/game-over state machine and saturating BCD survival score.
module collision_judge #(
  parameter int unsigned DINO_X = 50,
  parameter int unsigned DINO_W = 20,
  parameter int unsigned DINO_H = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_tick,
  input  logic        start,
  input  logic [8:0]  dino_pos,
  input  logic [8:0]  danger_pos1,
  input  logic [8:0]  danger_pos2,
  input  logic [8:0]  danger_pos3,
  input  logic [2:0]  danger_type1,
  input  logic [2:0]  danger_type2,
  input  logic [2:0]  danger_type3,
  input  logic        danger_en1,
  input  logic        danger_en2,
  input  logic        danger_en3,
  output logic        running,
  output logic        game_over,
  output logic [2:0]  hit_slot,
  output logic [15:0] score_bcd,
  output logic        frame_done
);

  localparam int unsigned PW = 9;   // input coordinate width
  localparam int unsigned CW = 10;  // overlap arithmetic width, wide enough to never wrap
  localparam int unsigned TW = 3;
  localparam int unsigned NS = 3;   // number of danger slots

  localparam logic [TW-1:0] T_LOW_BIRD    = 3'd0;
  localparam logic [TW-1:0] T_HIGH_BIRD   = 3'd1;
  localparam logic [TW-1:0] T_SMALL_CACTI = 3'd2;
  localparam logic [TW-1:0] T_MANY_CACTI  = 3'd3;
  localparam logic [TW-1:0] T_BIG_CACTUS  = 3'd4;

  typedef enum logic [1:0] {IDLE, RUN, CHK, OVER} state_t;

  state_t        state, state_n;
  logic [1:0]    idx, idx_n;
  logic [NS-1:0] acc, acc_n;
  logic [NS-1:0] hit_slot_n;
  logic [15:0]   score_n;
  logic          frame_done_n, running_n, game_over_n;
  logic          snap_load;

  logic [PW-1:0] snap_dino;
  logic [PW-1:0] snap_pos  [NS];
  logic [TW-1:0] snap_type [NS];
  logic [NS-1:0] snap_en;

  logic [PW-1:0] cur_pos;
  logic [TW-1:0] cur_type;
  logic          cur_en;
  logic [CW-1:0] box_w, box_top, box_bot;
  logic          box_valid;
  logic [CW-1:0] px, px_right, dy, dy_bot;
  logic          slot_hit;

  // Saturating 4-digit BCD increment.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    if (v == 16'h9999) r = v;
    return r;
  endfunction

  // Snapshot of all object inputs, taken on the accepted frame tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_dino <= '0;
      snap_en   <= '0;
      for (int i = 0; i < int'(NS); i++) begin
        snap_pos[i]  <= '0;
        snap_type[i] <= '0;
      end
    end else if (snap_load) begin
      snap_dino    <= dino_pos;
      snap_pos[0]  <= danger_pos1;
      snap_pos[1]  <= danger_pos2;
      snap_pos[2]  <= danger_pos3;
      snap_type[0] <= danger_type1;
      snap_type[1] <= danger_type2;
      snap_type[2] <= danger_type3;
      snap_en      <= {danger_en3, danger_en2, danger_en1};
    end
  end

  // Box decode and inclusive overlap test of the slot selected by idx.
  always_comb begin
    case (idx)
      2'd0:    begin cur_pos = snap_pos[0]; cur_type = snap_type[0]; cur_en = snap_en[0]; end
      2'd1:    begin cur_pos = snap_pos[1]; cur_type = snap_type[1]; cur_en = snap_en[1]; end
      default: begin cur_pos = snap_pos[2]; cur_type = snap_type[2]; cur_en = snap_en[2]; end
    endcase

    box_w     = CW'(1);
    box_top   = '0;
    box_bot   = '0;
    box_valid = 1'b1;
    case (cur_type)
      T_LOW_BIRD:    begin box_w = CW'(20); box_top = CW'(192); box_bot = CW'(207); end
      T_HIGH_BIRD:   begin box_w = CW'(20); box_top = CW'(170); box_bot = CW'(185); end
      T_SMALL_CACTI: begin box_w = CW'(10); box_top = CW'(202); box_bot = CW'(221); end
      T_MANY_CACTI:  begin box_w = CW'(26); box_top = CW'(202); box_bot = CW'(221); end
      T_BIG_CACTUS:  begin box_w = CW'(14); box_top = CW'(192); box_bot = CW'(221); end
      default:       box_valid = 1'b0;
    endcase

    px       = CW'(cur_pos);
    px_right = px + box_w - CW'(1);
    dy       = CW'(snap_dino);
    dy_bot   = dy + CW'(DINO_H - 1);
    slot_hit = box_valid && cur_en &&
               (px <= CW'(DINO_X + DINO_W - 1)) && (CW'(DINO_X) <= px_right) &&
               (box_top <= dy_bot) && (dy <= box_bot);
  end

  // Next-state and next-output logic of the run/check/game-over machine.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    acc_n        = acc;
    hit_slot_n   = hit_slot;
    score_n      = score_bcd;
    frame_done_n = 1'b0;
    snap_load    = 1'b0;

    case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        if (game_tick) begin
          state_n   = CHK;
          idx_n     = 2'd0;
          acc_n     = '0;
          snap_load = 1'b1;
        end
      end
      CHK: begin
        acc_n = acc | (NS'(slot_hit) << idx);
        if (idx == 2'd2) begin
          idx_n        = 2'd0;
          frame_done_n = 1'b1;
          if (|acc_n) begin
            state_n    = OVER;
            hit_slot_n = acc_n;
          end else begin
            state_n = RUN;
            score_n = bcd_inc(score_bcd);
          end
        end else begin
          idx_n = idx + 2'd1;
        end
      end
      OVER: begin
        if (start) begin
          state_n    = RUN;
          score_n    = '0;
          hit_slot_n = '0;
          acc_n      = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    running_n   = (state_n == RUN) || (state_n == CHK);
    game_over_n = (state_n == OVER);
  end

  // State, scan position, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      running    <= 1'b0;
      game_over  <= 1'b0;
      hit_slot   <= '0;
      score_bcd  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      acc        <= acc_n;
      running    <= running_n;
      game_over  <= game_over_n;
      hit_slot   <= hit_slot_n;
      score_bcd  <= score_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_collision_judge.sv
// Directed testbench for collision_judge.
module tb_collision_judge;

  logic        clk = 1'b0;
  logic        rst, game_tick, start;
  logic [8:0]  dino_pos;
  logic [8:0]  danger_pos1, danger_pos2, danger_pos3;
  logic [2:0]  danger_type1, danger_type2, danger_type3;
  logic        danger_en1, danger_en2, danger_en3;
  logic        running, game_over, frame_done;
  logic [2:0]  hit_slot;
  logic [15:0] score_bcd;

  int nvec = 0;
  int nerr = 0;
  int exp_score = 0;
  logic fd;

  collision_judge dut (
    .clk(clk), .rst(rst), .game_tick(game_tick), .start(start),
    .dino_pos(dino_pos),
    .danger_pos1(danger_pos1), .danger_pos2(danger_pos2), .danger_pos3(danger_pos3),
    .danger_type1(danger_type1), .danger_type2(danger_type2), .danger_type3(danger_type3),
    .danger_en1(danger_en1), .danger_en2(danger_en2), .danger_en3(danger_en3),
    .running(running), .game_over(game_over), .hit_slot(hit_slot),
    .score_bcd(score_bcd), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic clear_slots();
    danger_pos1 = 9'd0; danger_type1 = 3'd7; danger_en1 = 1'b0;
    danger_pos2 = 9'd0; danger_type2 = 3'd7; danger_en2 = 1'b0;
    danger_pos3 = 9'd0; danger_type3 = 3'd7; danger_en3 = 1'b0;
  endtask

  task automatic set_slot(input int s, input int p, input int t, input logic e);
    case (s)
      1:       begin danger_pos1 = 9'(p); danger_type1 = 3'(t); danger_en1 = e; end
      2:       begin danger_pos2 = 9'(p); danger_type2 = 3'(t); danger_en2 = e; end
      default: begin danger_pos3 = 9'(p); danger_type3 = 3'(t); danger_en3 = e; end
    endcase
  endtask

  // Tick in cycle T, return in cycle T+4 with frame_done sampled there.
  task automatic run_frame(output logic f);
    game_tick = 1'b1;
    @(negedge clk);
    game_tick = 1'b0;
    repeat (3) @(negedge clk);
    f = frame_done;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; game_tick = 1'b0; start = 1'b0; dino_pos = 9'd200;
    clear_slots();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nvec++; if (running !== 1'b0) begin nerr++; $display("FAIL reset_running: got %b want 0", running); end
    nvec++; if (game_over !== 1'b0) begin nerr++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    nvec++; if (hit_slot !== 3'b000) begin nerr++; $display("FAIL reset_hit_slot: got %b want 000", hit_slot); end
    nvec++; if (score_bcd !== 16'h0000) begin nerr++; $display("FAIL reset_score: got %h want 0000", score_bcd); end
    nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    // tick while idle is dropped
    run_frame(fd);
    nvec++; if (fd !== 1'b0) begin nerr++; $display("FAIL idle_tick_dropped: got %b want 0", fd); end
  endtask

  task automatic test_start();
    pulse_start();
    nvec++; if (running !== 1'b1) begin nerr++; $display("FAIL start_running: got %b want 1", running); end
  endtask

  task automatic test_clean_frames();
    for (int i = 0; i < 10; i++) begin
      run_frame(fd);
      exp_score++;
      nvec++; if (fd !== 1'b1) begin nerr++; $display("FAIL clean_frame_done[%0d]: got %b want 1", i, fd); end
      nvec++; if (score_bcd !== to_bcd(exp_score)) begin nerr++; $display("FAIL clean_score[%0d]: got %h want %h", i, score_bcd, to_bcd(exp_score)); end
    end
    nvec++; if (score_bcd !== 16'h0010) begin nerr++; $display("FAIL bcd_carry: got %h want 0010", score_bcd); end
    @(negedge clk);
    nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL frame_done_one_cycle: got %b want 0", frame_done); end
  endtask

  task automatic test_hit_slot2();
    dino_pos = 9'd200;
    set_slot(2, 60, 2, 1'b1);
    run_frame(fd);
    nvec++; if (game_over !== 1'b1) begin nerr++; $display("FAIL slot2_game_over: got %b want 1", game_over); end
    nvec++; if (running !== 1'b0) begin nerr++; $display("FAIL slot2_running: got %b want 0", running); end
    nvec++; if (hit_slot !== 3'b010) begin nerr++; $display("FAIL slot2_hit_slot: got %b want 010", hit_slot); end
    nvec++; if (score_bcd !== to_bcd(exp_score)) begin nerr++; $display("FAIL slot2_score_held: got %h want %h", score_bcd, to_bcd(exp_score)); end
    // tick in OVER is dropped, start restarts
    run_frame(fd);
    nvec++; if (fd !== 1'b0) begin nerr++; $display("FAIL over_tick_dropped: got %b want 0", fd); end
    pulse_start();
    exp_score = 0;
    nvec++; if (game_over !== 1'b0) begin nerr++; $display("FAIL restart_game_over: got %b want 0", game_over); end
    nvec++; if (score_bcd !== 16'h0000) begin nerr++; $display("FAIL restart_score: got %h want 0000", score_bcd); end
    set_slot(2, 70, 2, 1'b1);
    run_frame(fd);
    exp_score++;
    nvec++; if (game_over !== 1'b0) begin nerr++; $display("FAIL slot2_x70_game_over: got %b want 0", game_over); end
    nvec++; if (score_bcd !== to_bcd(exp_score)) begin nerr++; $display("FAIL slot2_x70_score: got %h want %h", score_bcd, to_bcd(exp_score)); end
    clear_slots();
  endtask

  task automatic test_x_boundary();
    dino_pos = 9'd200;
    set_slot(1, 40, 2, 1'b1);
    run_frame(fd);
    exp_score++;
    nvec++; if (game_over !== 1'b0) begin nerr++; $display("FAIL x40_game_over: got %b want 0", game_over); end
    nvec++; if (score_bcd !== to_bcd(exp_score)) begin nerr++; $display("FAIL x40_score: got %h want %h", score_bcd, to_bcd(exp_score)); end
    set_slot(1, 41, 2, 1'b1);
    run_frame(fd);
    nvec++; if (hit_slot !== 3'b001) begin nerr++; $display("FAIL x41_hit_slot: got %b want 001", hit_slot); end
    nvec++; if (score_bcd !== to_bcd(exp_score)) begin nerr++; $display("FAIL x41_score_held: got %h want %h", score_bcd, to_bcd(exp_score)); end
    clear_slots();
    pulse_start();
    exp_score = 0;
  endtask

  task automatic test_y_boundary();
    dino_pos = 9'd170;
    set_slot(1, 50, 0, 1'b1);
    run_frame(fd);
    exp_score++;
    nvec++; if (game_over !== 1'b0) begin nerr++; $display("FAIL y170_low_bird: got %b want 0", game_over); end
    dino_pos = 9'd171;
    run_frame(fd);
    nvec++; if (hit_slot !== 3'b001) begin nerr++; $display("FAIL y171_low_bird: got %b want 001", hit_slot); end
    pulse_start();
    exp_score = 0;
    dino_pos = 9'd200;
    set_slot(1, 50, 1, 1'b1);
    run_frame(fd);
    exp_score++;
    nvec++; if (game_over !== 1'b0) begin nerr++; $display("FAIL high_bird_y200: got %b want 0", game_over); end
    nvec++; if (score_bcd !== to_bcd(exp_score)) begin nerr++; $display("FAIL high_bird_score: got %h want %h", score_bcd, to_bcd(exp_score)); end
    clear_slots();
  endtask

  task automatic test_multi_hit();
    dino_pos = 9'd200;
    set_slot(1, 55, 2, 1'b1);
    set_slot(2, 55, 5, 1'b1);
    set_slot(3, 60, 4, 1'b1);
    run_frame(fd);
    nvec++; if (hit_slot !== 3'b101) begin nerr++; $display("FAIL multi_hit_slot: got %b want 101", hit_slot); end
    clear_slots();
    pulse_start();
    exp_score = 0;
    nvec++; if (hit_slot !== 3'b000) begin nerr++; $display("FAIL multi_restart_hit: got %b want 000", hit_slot); end
    nvec++; if (score_bcd !== 16'h0000) begin nerr++; $display("FAIL multi_restart_score: got %h want 0000", score_bcd); end
    nvec++; if (running !== 1'b1) begin nerr++; $display("FAIL multi_restart_running: got %b want 1", running); end
  endtask

  task automatic test_back_to_back();
    dino_pos = 9'd200;
    clear_slots();
    game_tick = 1'b1;                     // T
    @(negedge clk); game_tick = 1'b0;     // T+1: colliding input after snapshot
    set_slot(1, 55, 2, 1'b1);
    start = 1'b1;                         // start during CHK is ignored
    @(negedge clk); game_tick = 1'b1;     // T+2: tick during CHK is dropped
    start = 1'b0;
    @(negedge clk); game_tick = 1'b0;     // T+3
    @(negedge clk);                       // T+4
    exp_score++;
    nvec++; if (frame_done !== 1'b1) begin nerr++; $display("FAIL b2b_frame1_done: got %b want 1", frame_done); end
    nvec++; if (game_over !== 1'b0) begin nerr++; $display("FAIL snapshot_no_hit: got %b want 0", game_over); end
    nvec++; if (score_bcd !== to_bcd(exp_score)) begin nerr++; $display("FAIL b2b_score1: got %h want %h", score_bcd, to_bcd(exp_score)); end
    clear_slots();
    run_frame(fd);                        // tick at T+4 is accepted
    exp_score++;
    nvec++; if (fd !== 1'b1) begin nerr++; $display("FAIL b2b_frame2_done: got %b want 1", fd); end
    nvec++; if (score_bcd !== to_bcd(exp_score)) begin nerr++; $display("FAIL b2b_score2: got %h want %h", score_bcd, to_bcd(exp_score)); end
    repeat (5) @(negedge clk);
    nvec++; if (score_bcd !== to_bcd(exp_score)) begin nerr++; $display("FAIL b2b_no_queue: got %h want %h", score_bcd, to_bcd(exp_score)); end
  endtask

  task automatic test_saturation();
    clear_slots();
    for (int i = exp_score; i < 9999; i++) run_frame(fd);
    exp_score = 9999;
    nvec++; if (score_bcd !== 16'h9999) begin nerr++; $display("FAIL score_9999: got %h want 9999", score_bcd); end
    run_frame(fd);
    nvec++; if (fd !== 1'b1) begin nerr++; $display("FAIL sat_frame_done: got %b want 1", fd); end
    nvec++; if (score_bcd !== 16'h9999) begin nerr++; $display("FAIL score_saturate: got %h want 9999", score_bcd); end
  endtask

  task automatic test_reset_mid_chk();
    game_tick = 1'b1;                     // T
    @(negedge clk); game_tick = 1'b0;     // T+1
    @(negedge clk); rst = 1'b1;           // T+2, second check cycle
    @(negedge clk); rst = 1'b0;           // T+3
    nvec++; if (running !== 1'b0) begin nerr++; $display("FAIL rst_chk_running: got %b want 0", running); end
    nvec++; if (score_bcd !== 16'h0000) begin nerr++; $display("FAIL rst_chk_score: got %h want 0000", score_bcd); end
    nvec++; if (game_over !== 1'b0 || hit_slot !== 3'b000) begin nerr++; $display("FAIL rst_chk_status: got %b/%b want 0/000", game_over, hit_slot); end
    nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL rst_chk_fd_t3: got %b want 0", frame_done); end
    @(negedge clk);                       // T+4
    nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL rst_chk_fd_t4: got %b want 0", frame_done); end
    run_frame(fd);                        // idle again: tick dropped
    nvec++; if (fd !== 1'b0 || running !== 1'b0) begin nerr++; $display("FAIL rst_chk_idle: got fd=%b run=%b want 0/0", fd, running); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_start();
    test_clean_frames();
    test_hit_slot2();
    test_x_boundary();
    test_y_boundary();
    test_multi_hit();
    test_back_to_back();
    test_saturation();
    test_reset_mid_chk();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
